// File: rtl/robin_pkg.sv
// robin_pkg: command/reply byte codes and the FSM state type shared by serial_monitor.
// S_CSUM only exists when SERIAL_MONITOR_CHECKSUM_EN is defined.
package robin_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BAD   = 8'h3F;
  localparam logic [7:0] RSP_CSUM  = 8'h45;

  typedef enum logic [3:0] {
    S_IDLE,
    S_AH,
    S_AL,
    S_LEN,
    S_WDATA,
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    S_CSUM,
`endif
    S_RREQ,
    S_RWAIT,
    S_RSEND,
    S_ACK,
    S_ERR
  } state_t;

endpackage

// File: rtl/serial_monitor.sv
// serial_monitor: byte-stream 'W'/'R' command engine between the UART FIFOs and low memory.
// Build option SERIAL_MONITOR_CHECKSUM_EN adds a trailing mod-256 checksum byte to writes.
//
// state   | meaning
// IDLE    | wait for command byte
// AH/AL   | address high / low byte
// LEN     | length byte (0 = 256)
// WDATA   | one memory write per received byte
// CSUM    | trailing checksum byte (checksum build only)
// RREQ    | present read address
// RWAIT   | memory read latency
// RSEND   | push read byte to TX
// ACK     | push write reply
// ERR     | flag bad command, push '?'
module serial_monitor #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_empty,
  input  logic [7:0]            rx_data,
  output logic                  rx_read,
  input  logic                  tx_full,
  output logic [7:0]            tx_data,
  output logic                  tx_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  cmd_error
);
  import robin_pkg::*;

  state_t                  state, state_nxt;
  logic                    is_write, is_write_nxt;
  logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
  logic [8:0]              count, count_nxt;
  logic                    rx_read_nxt, tx_write_nxt, mem_we_nxt, busy_nxt, cmd_error_nxt;
  logic [7:0]              tx_data_nxt, mem_wdata_nxt;
  logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic                    rx_ok, tx_ok;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
  logic [7:0]              sum, sum_nxt;
  logic                    csum_ok, csum_ok_nxt;
`endif

  // Gating on our own previous strobe keeps pops/pushes at least one cycle apart.
  assign rx_ok = !rx_empty && !rx_read;
  assign tx_ok = !tx_full && !tx_write;

  always_comb begin
    state_nxt     = state;
    is_write_nxt  = is_write;
    addr_nxt      = addr;
    count_nxt     = count;
    rx_read_nxt   = 1'b0;
    tx_write_nxt  = 1'b0;
    tx_data_nxt   = tx_data;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    cmd_error_nxt = 1'b0;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    sum_nxt       = sum;
    csum_ok_nxt   = csum_ok;
`endif
    case (state)
      S_IDLE: if (rx_ok) begin
        rx_read_nxt = 1'b1;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        sum_nxt = 8'h00;
`endif
        if (rx_data == CMD_WRITE) begin
          is_write_nxt = 1'b1;
          state_nxt    = S_AH;
        end else if (rx_data == CMD_READ) begin
          is_write_nxt = 1'b0;
          state_nxt    = S_AH;
        end else begin
          state_nxt = S_ERR;
        end
      end
      S_AH: if (rx_ok) begin
        rx_read_nxt                 = 1'b1;
        addr_nxt[ADDR_WIDTH-1:8]    = rx_data[ADDR_WIDTH-9:0];
        state_nxt                   = S_AL;
      end
      S_AL: if (rx_ok) begin
        rx_read_nxt   = 1'b1;
        addr_nxt[7:0] = rx_data;
        state_nxt     = S_LEN;
      end
      S_LEN: if (rx_ok) begin
        rx_read_nxt = 1'b1;
        count_nxt   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        state_nxt   = is_write ? S_WDATA : S_RREQ;
      end
      S_WDATA: if (rx_ok) begin
        rx_read_nxt   = 1'b1;
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = addr;
        mem_wdata_nxt = rx_data;
        addr_nxt      = addr + 1'b1;
        count_nxt     = count - 9'd1;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        sum_nxt       = sum + rx_data;
        if (count == 9'd1) state_nxt = S_CSUM;
`else
        if (count == 9'd1) state_nxt = S_ACK;
`endif
      end
`ifdef SERIAL_MONITOR_CHECKSUM_EN
      S_CSUM: if (rx_ok) begin
        rx_read_nxt = 1'b1;
        csum_ok_nxt = (rx_data == sum);
        state_nxt   = S_ACK;
      end
`endif
      S_RREQ: begin
        mem_addr_nxt = addr;
        state_nxt    = S_RWAIT;
      end
      S_RWAIT: state_nxt = S_RSEND;
      // mem_addr is held while stalled, so mem_rdata stays valid here.
      S_RSEND: if (tx_ok) begin
        tx_write_nxt = 1'b1;
        tx_data_nxt  = mem_rdata;
        addr_nxt     = addr + 1'b1;
        count_nxt    = count - 9'd1;
        state_nxt    = (count == 9'd1) ? S_IDLE : S_RREQ;
      end
      S_ACK: if (tx_ok) begin
        tx_write_nxt = 1'b1;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        tx_data_nxt  = csum_ok ? RSP_OK : RSP_CSUM;
`else
        tx_data_nxt  = RSP_OK;
`endif
        state_nxt    = S_IDLE;
      end
      S_ERR: if (tx_ok) begin
        tx_write_nxt  = 1'b1;
        tx_data_nxt   = RSP_BAD;
        cmd_error_nxt = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      is_write  <= 1'b0;
      addr      <= '0;
      count     <= 9'd0;
      rx_read   <= 1'b0;
      tx_write  <= 1'b0;
      tx_data   <= 8'h00;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      cmd_error <= 1'b0;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
      sum       <= 8'h00;
      csum_ok   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      is_write  <= is_write_nxt;
      addr      <= addr_nxt;
      count     <= count_nxt;
      rx_read   <= rx_read_nxt;
      tx_write  <= tx_write_nxt;
      tx_data   <= tx_data_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= busy_nxt;
      cmd_error <= cmd_error_nxt;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
      sum       <= sum_nxt;
      csum_ok   <= csum_ok_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_monitor.sv
// tb_serial_monitor: randomized command traffic checked against a byte-level reference model.
// Honours SERIAL_MONITOR_CHECKSUM_EN the same way as the design.
module tb_serial_monitor;
  localparam int AW = 13;
  localparam int MEM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_empty = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_read;
  logic          tx_full = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_write;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata = 8'h00;
  logic          busy;
  logic          cmd_error;

  always #5 clk = ~clk;

  serial_monitor #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_empty(rx_empty), .rx_data(rx_data), .rx_read(rx_read),
    .tx_full(tx_full), .tx_data(tx_data), .tx_write(tx_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .cmd_error(cmd_error)
  );

  logic [7:0] mem [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];
  logic [7:0] rx_q[$], tx_got[$], exp_tx[$], cmd_q[$], wdat[$];
  int n_vec = 0, n_err = 0;
  int we_cnt = 0, err_cnt = 0, exp_we = 0, exp_err = 0;
  int consec_rx = 0, consec_tx = 0, bp_viol = 0;
  logic rx_read_q = 1'b0, tx_write_q = 1'b0, tx_full_q = 1'b0;
  bit loaded = 1'b0;
  int bp_mode = 0;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 29 + 7) ^ (i >> 8));
  endfunction

  // Memory with one-cycle read latency, preloaded with a known pattern.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= pat(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // First-word-fall-through receive FIFO.
  always @(posedge clk) begin
    if (rx_read && rx_q.size() > 0) void'(rx_q.pop_front());
    rx_empty <= (rx_q.size() == 0);
    rx_data  <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (tx_write) tx_got.push_back(tx_data);
    if (mem_we) we_cnt <= we_cnt + 1;
    if (cmd_error) err_cnt <= err_cnt + 1;
    if (tx_write && tx_full_q) bp_viol <= bp_viol + 1;
    if (rx_read && rx_read_q) consec_rx <= consec_rx + 1;
    if (tx_write && tx_write_q) consec_tx <= consec_tx + 1;
    rx_read_q  <= rx_read;
    tx_write_q <= tx_write;
    tx_full_q  <= tx_full;
  end

  initial forever begin
    @(negedge clk);
    case (bp_mode)
      1:       tx_full = 1'b1;
      2:       tx_full = ($urandom_range(0, 2) == 0);
      default: tx_full = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd();
    while (cmd_q.size() > 0) begin
      @(negedge clk);
      rx_q.push_back(cmd_q.pop_front());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      done = (rx_q.size() == 0) && rx_empty && !rx_read && !busy;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_tx_len"}, tx_got.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
      chk({tag, "_tx_byte"}, 32'(tx_got[i]), 32'(exp_tx[i]));
    chk({tag, "_we_cnt"}, we_cnt, exp_we);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    tx_got.delete();
    exp_tx.delete();
  endtask

  task automatic do_write(input int a, input bit bad_sum);
    int n = wdat.size();
    logic [7:0] sum = 8'h00;
    cmd_q.push_back(8'h57);
    cmd_q.push_back(8'(a >> 8));
    cmd_q.push_back(8'(a));
    cmd_q.push_back(8'((n == 256) ? 0 : n));
    for (int i = 0; i < n; i++) begin
      cmd_q.push_back(wdat[i]);
      ref_mem[((a & (MEM_SIZE - 1)) + i) % MEM_SIZE] = wdat[i];
      sum = sum + wdat[i];
    end
    exp_we += n;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    cmd_q.push_back(bad_sum ? sum + 8'd1 : sum);
    exp_tx.push_back(bad_sum ? 8'h45 : 8'h4B);
`else
    if (bad_sum) sum = 8'h00;
    exp_tx.push_back(8'h4B);
`endif
    push_cmd();
  endtask

  task automatic do_read(input int a, input int n);
    cmd_q.push_back(8'h52);
    cmd_q.push_back(8'(a >> 8));
    cmd_q.push_back(8'(a));
    cmd_q.push_back(8'((n == 256) ? 0 : n));
    for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[((a & (MEM_SIZE - 1)) + i) % MEM_SIZE]);
    push_cmd();
  endtask

  task automatic do_bad(input logic [7:0] b);
    cmd_q.push_back(b);
    exp_tx.push_back(8'h3F);
    exp_err++;
    push_cmd();
  endtask

  initial begin
    int cyc, r, a, n, diffs;
    logic [7:0] b;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = pat(i);
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_rx_read", 32'(rx_read), 0);
    chk("rst_tx_write", 32'(tx_write), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_error", 32'(cmd_error), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    wdat = '{8'hAA, 8'hBB, 8'hCC};
    do_write(16'h0010, 1'b0);
    wait_done("wr3");
    compare("wr3");
    do_read(16'h0010, 3);
    wait_done("rd3");
    compare("rd3");
    chk("mem_10", 32'(mem[16'h10]), 32'hAA);
    chk("mem_12", 32'(mem[16'h12]), 32'hCC);

    do_read(16'h0000, 256);
    wait_done("rd256");
    compare("rd256");

    wdat = '{8'h11, 8'h22};
    do_write(16'hFFFF, 1'b0);
    wait_done("wrap");
    compare("wrap");
    chk("mem_1fff", 32'(mem[13'h1FFF]), 32'h11);
    chk("mem_0000", 32'(mem[0]), 32'h22);

    bp_mode = 1;
    repeat (2) @(negedge clk);
    do_read(16'h0100, 4);
    repeat (60) @(negedge clk);
    chk("bp_no_push", tx_got.size(), 0);
    chk("bp_busy", 32'(busy), 1);
    bp_mode = 0;
    wait_done("bp");
    compare("bp");

    do_bad(8'h41);
    wait_done("bad");
    compare("bad");

    cmd_q = '{8'h57, 8'h00, 8'h20, 8'h04, 8'hAA};
    push_cmd();
    cyc = 0;
    while (we_cnt != exp_we + 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_we_seen", we_cnt, exp_we + 1);
    exp_we++;
    ref_mem[16'h20] = 8'hAA;
    reset_n = 1'b0;
    rx_q.delete();
    repeat (3) @(negedge clk);
    chk("rstmid_busy", 32'(busy), 0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    compare("rstmid");
    chk("rstmid_mem20", 32'(mem[16'h20]), 32'hAA);
    chk("rstmid_mem21", 32'(mem[16'h21]), 32'(pat(16'h21)));
    do_read(16'h0020, 1);
    wait_done("rstrd");
    compare("rstrd");

`ifdef SERIAL_MONITOR_CHECKSUM_EN
    wdat = '{8'h01, 8'h02};
    do_write(16'h0000, 1'b0);
    wait_done("csum_ok");
    compare("csum_ok");
    do_write(16'h0000, 1'b1);
    wait_done("csum_bad");
    compare("csum_bad");
    chk("csum_mem0", 32'(mem[0]), 32'h01);
    chk("csum_mem1", 32'(mem[1]), 32'h02);
`endif

    bp_mode = 2;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 65535);
      n = ($urandom_range(0, 19) == 0) ? 256 : $urandom_range(1, 12);
      if (r == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        do_bad(b);
      end else if (r < 5) begin
        wdat.delete();
        for (int i = 0; i < n; i++) wdat.push_back(8'($urandom_range(0, 255)));
        do_write(a, $urandom_range(0, 2) == 0);
      end else begin
        do_read(a, n);
      end
      wait_done("rnd");
      compare("rnd");
    end
    bp_mode = 0;
    repeat (3) @(negedge clk);

    diffs = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", diffs, 0);
    chk("rx_read_consecutive", consec_rx, 0);
    chk("tx_write_consecutive", consec_tx, 0);
    chk("tx_write_while_full", bp_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_monitor.md
Name: serial_monitor

Overview:
- Byte-stream command engine directly downstream of the UART receive FIFO.
- Pops command bytes, decodes memory write/read commands and drives the on-chip low memory port (8 KiB).
- Pushes reply bytes into the transmit FIFO feeding the UART transmitter.
- Replaces the plain echo loop as the host's path to load and inspect memory.

Parameters:
- ADDR_WIDTH, 13: memory address width; 2^13 = 8 KiB.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_empty  in  1  receive FIFO empty
- rx_data  in  8  receive FIFO head byte; valid whenever rx_empty=0 (first-word fall-through)
- rx_read  out  1  one-cycle pop of the receive FIFO
- tx_full  in  1  transmit FIFO full
- tx_data  out  8  byte to push
- tx_write  out  1  one-cycle push into the transmit FIFO
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe, one cycle per byte
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_addr is presented
- busy  out  1  high whenever state != IDLE
- cmd_error  out  1  one-cycle pulse on an unknown command byte

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: rx_read=0, tx_write=0, tx_data=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, cmd_error=0; state IDLE; internal address, count and checksum registers = 0.
- All outputs are registered.
- Receive pop rule:
  - A byte is consumed only when rx_empty=0 is sampled; rx_read pulses in that same registered cycle.
  - rx_read is never high on two consecutive cycles, giving the FIFO one cycle to update its head and empty flag.
- Transmit push rule:
  - tx_write pulses only when tx_full=0 was sampled that cycle.
  - tx_write is never high on two consecutive cycles.
  - The engine holds state while tx_full=1.
- States and transitions:
  - IDLE: on a byte: 0x57 'W' -> AH with op=write; 0x52 'R' -> AH with op=read; any other byte -> ERR.
  - AH: addr[15:8]. AL: addr[7:0]. LEN: len byte; 0 means 256. Each consumes exactly one byte.
  - LEN with op=write -> WDATA; with op=read -> RREQ.
  - WDATA: per byte, mem_addr=addr, mem_wdata=byte, mem_we=1 for one cycle; then addr+1 and count-1. When count reaches 0 -> ACK.
  - RREQ: present mem_addr, then wait one cycle (RWAIT) -> RSEND.
  - RSEND: capture mem_rdata, push it when tx_full=0, then addr+1 and count-1. count=0 -> IDLE, otherwise -> RREQ.
  - ACK: push 0x4B 'K' -> IDLE.
  - ERR: pulse cmd_error, push 0x3F '?' -> IDLE.
- Address arithmetic:
  - The received 16-bit address is truncated to its low ADDR_WIDTH bits.
  - The increment wraps modulo 2^ADDR_WIDTH; 0x1FFF+1 = 0x0000.
  - The count register is 9 bits.
- Stalls: no timeout. A command stalled mid-stream waits indefinitely for the next byte, with no side effects.
- Reset mid-command: abandon immediately and return to IDLE. Completed memory writes stand; no reply is sent.
- Simultaneous events: a FIFO byte and tx_full=0 in the same cycle are never both acted on unless the state requires both; only one action occurs per state per cycle.

Optional Feature:
- Macro: SERIAL_MONITOR_CHECKSUM_EN.
- When defined:
  - A 'W' command carries one trailing byte after its data, consumed in state CSUM.
  - That byte must equal the 8-bit modulo-256 sum of the data bytes.
  - On a match the reply is 'K'; on a mismatch the reply is 0x45 'E'.
  - Memory writes are performed regardless of the checksum result.
- When undefined: no trailing byte and no CSUM state; 'W' always replies 'K'.

Decomposition:
- Shared package robin_pkg holds:
  - Command constants CMD_WRITE=0x57 and CMD_READ=0x52.
  - Reply constants RSP_OK=0x4B, RSP_BAD=0x3F, RSP_CSUM=0x45.
  - The state enumeration type.
- No sub-module: a single FSM plus datapath of roughly 200 lines.

Test Plan:
- Write then read: send 57 00 10 03 AA BB CC, then 52 00 10 03 -> mem[0x10..0x12]=AA,BB,CC with three mem_we pulses; TX carries 4B, then AA BB CC.
- Length 0 read: send 52 00 00 00 -> exactly 256 TX bytes, addresses 0x000..0x0FF.
- Address wrap and truncation: send 57 FF FF 02 11 22 -> address truncates to 0x1FFF; mem[0x1FFF]=11, mem[0x0000]=22; reply 4B.
- Back-pressure: hold tx_full=1 during a 4-byte read -> no tx_write pulses and state held; release -> bytes delivered in order with no loss or duplication; rx_read and tx_write never high on consecutive cycles.
- Bad command and reset recovery:
  - Send 0x41 -> one cmd_error pulse and TX 3F.
  - Assert reset_n low after 57 00 20 04 AA -> mem[0x20]=AA only, no reply.
  - Then send 52 00 20 01 -> TX AA.
- With SERIAL_MONITOR_CHECKSUM_EN: send 57 00 00 02 01 02 03 -> reply 4B; send 57 00 00 02 01 02 04 -> reply 45; in both cases mem[0..1]=01,02.
